alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 38 +++
 rtl/alu_mc.sv | 205 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Purpose  : Request/response bundle for the multi-cycle ALU.
//            master side issues operations and accepts results,
//            slave side (the ALU) accepts operations and presents results.
// Signals  : in_valid/in_ready   - request handshake
//            alu_op, a, b         - operation code and operands
//            out_valid/out_ready  - result handshake
//            f, zf, cf, of        - result and zero/carry/overflow flags
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             zf;
    logic             cf;
    logic             of;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, f, zf, cf, of
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, f, zf, cf, of
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Handshaked ALU. Logic, add/sub, compares and shifts complete in
//            one cycle; MUL runs a shift-and-add loop, one multiplier bit per
//            cycle. Results and flags are registered and held until retired.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - alu_mc_if slave (request, operands, result, flags)
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_XOR  = 4'd2;
    localparam logic [3:0] c_OP_XNOR = 4'd3;
    localparam logic [3:0] c_OP_ADD  = 4'd4;
    localparam logic [3:0] c_OP_SUB  = 4'd5;
    localparam logic [3:0] c_OP_SLTU = 4'd6;
    localparam logic [3:0] c_OP_SLT  = 4'd7;
    localparam logic [3:0] c_OP_SLL  = 4'd8;
    localparam logic [3:0] c_OP_SRL  = 4'd9;
    localparam logic [3:0] c_OP_SRA  = 4'd10;
    localparam logic [3:0] c_OP_MUL  = 4'd11;

    // Counter must reach WIDTH: WIDTH step cycles, then one cycle that
    // publishes the product.
    localparam int                 c_CNT_W    = SHW + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_f;
    logic               r_zf;
    logic               r_cf;
    logic               r_of;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic [WIDTH-1:0]   w_f;
    logic               w_cf;
    logic               w_of;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [SHW-1:0]     w_shamt;
    logic               w_mul_last;

    assign w_mul_last = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Single-cycle result from the live operands; only sampled at accept.
    // ------------------------------------------------------------------
    always_comb begin
        w_f     = '0;
        w_cf    = 1'b0;
        w_of    = 1'b0;
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff  = bus.a - bus.b;
        w_shamt = bus.b[SHW-1:0];
        case (bus.alu_op)
            c_OP_AND:  w_f = bus.a & bus.b;
            c_OP_OR:   w_f = bus.a | bus.b;
            c_OP_XOR:  w_f = bus.a ^ bus.b;
            c_OP_XNOR: w_f = ~(bus.a ^ bus.b);
            c_OP_ADD: begin
                w_f  = w_sum[WIDTH-1:0];
                w_cf = w_sum[WIDTH];
                w_of = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_f  = w_diff;
                w_cf = (bus.a < bus.b);
                w_of = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_OP_SLTU: w_f = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            c_OP_SLT:  w_f = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            c_OP_SLL:  w_f = bus.a << w_shamt;
            c_OP_SRL:  w_f = bus.a >> w_shamt;
            c_OP_SRA:  w_f = $unsigned($signed(bus.a) >>> w_shamt);
            default:   w_f = '0;  // MUL handled by the loop; reserved give 0
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs (state decode only)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = (bus.alu_op == c_OP_MUL) ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (w_mul_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                // Retiring edge returns to IDLE; in_ready is low here, so
                // no request can be taken on the same edge.
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: result registers and shift-and-add multiplier
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f      <= '0;
            r_zf     <= 1'b0;
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.alu_op == c_OP_MUL) begin
                            r_prod   <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                            r_cnt    <= '0;
                        end else begin
                            r_f  <= w_f;
                            r_zf <= ~|w_f;
                            r_cf <= w_cf;
                            r_of <= w_of;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_mul_last) begin
                        r_f  <= r_prod[WIDTH-1:0];
                        r_zf <= ~|r_prod[WIDTH-1:0];
                        r_cf <= 1'b0;
                        r_of <= |r_prod[2*WIDTH-1:WIDTH];
                    end else begin
                        if (r_mplier[0]) begin
                            r_prod <= r_prod + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;  // DONE holds the result
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.f         = r_f;
    assign bus.zf        = r_zf;
    assign bus.cf        = r_cf;
    assign bus.of        = r_of;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (WIDTH=32). Expected results are
//            queued when a request is driven and popped when the result
//            appears. Latency k counts rising edges after the accept edge
//            until out_valid is seen: 0 for single-cycle ops, 33 for MUL.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    typedef struct packed {
        logic [31:0] f;
        logic        zf;
        logic        cf;
        logic        of;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    res_t sb_q[$];

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t mk(input logic [31:0] f, input logic cf, input logic of);
        res_t r;
        r.f  = f;
        r.zf = (f == 32'd0);
        r.cf = cf;
        r.of = of;
        return r;
    endfunction

    // Reference model used for the random sweep.
    function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [63:0] p;
        logic [31:0] f;
        logic        cf;
        logic        of;
        f = 32'd0; cf = 1'b0; of = 1'b0;
        case (op)
            4'd0: f = a & b;
            4'd1: f = a | b;
            4'd2: f = a ^ b;
            4'd3: f = ~(a ^ b);
            4'd4: begin
                s  = {1'b0, a} + {1'b0, b};
                f  = s[31:0];
                cf = s[32];
                of = (a[31] == b[31]) && (f[31] != a[31]);
            end
            4'd5: begin
                f  = a - b;
                cf = (a < b);
                of = (a[31] != b[31]) && (f[31] != a[31]);
            end
            4'd6: f = (a < b) ? 32'd1 : 32'd0;
            4'd7: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: f = a << b[4:0];
            4'd9: f = a >> b[4:0];
            4'd10: f = $unsigned($signed(a) >>> b[4:0]);
            4'd11: begin
                p  = {32'd0, a} * {32'd0, b};
                f  = p[31:0];
                of = |p[63:32];
            end
            default: f = 32'd0;
        endcase
        return mk(f, cf, of);
    endfunction

    // Drive one request and push its expectation; operands are scrambled
    // right after the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input res_t exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.alu_op   = 4'($urandom_range(15, 0));
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic wait_result(output bit to, output int k, output res_t act);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        to     = !bus.out_valid;
        act.f  = bus.f;
        act.zf = bus.zf;
        act.cf = bus.cf;
        act.of = bus.of;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.f, bus.zf, bus.cf, bus.of} !== 36'd0)
            $display("FAIL reset_state: got out_valid=%b f=%h zf=%b cf=%b of=%b, expected all 0",
                     bus.out_valid, bus.f, bus.zf, bus.cf, bus.of);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_arith();
        logic [3:0]  ops [3] = '{4'd4, 4'd5, 4'd5};
        logic [31:0] as  [3] = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
        logic [31:0] bs  [3] = '{32'h1, 32'h1, 32'h1};
        res_t        exs [3];
        bit to; int k; res_t act, exp;
        exs[0] = mk(32'h8000_0000, 1'b0, 1'b1);
        exs[1] = mk(32'hFFFF_FFFF, 1'b1, 1'b0);
        exs[2] = mk(32'h7FFF_FFFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(ops[i], as[i], bs[i], exs[i]);
            wait_result(to, k, act);
            exp = sb_q.pop_front();
            n_checks++;
            if (to || k != 0) $display("FAIL arith_latency[%0d]: got k=%0d timeout=%b, expected k=0", i, k, to);
            else n_pass++;
            n_checks++;
            if (act !== exp)
                $display("FAIL arith_result[%0d]: got f=%h zf=%b cf=%b of=%b, expected f=%h zf=%b cf=%b of=%b",
                         i, act.f, act.zf, act.cf, act.of, exp.f, exp.zf, exp.cf, exp.of);
            else n_pass++;
            retire();
        end
    endtask

    task automatic test_mul();
        logic [31:0] as [2] = '{32'h0001_0000, 32'h3};
        logic [31:0] bs [2] = '{32'h0001_0000, 32'h607};
        res_t        exs[2];
        bit to; int k; res_t act, exp;
        exs[0] = mk(32'h0, 1'b0, 1'b1);
        exs[1] = mk(32'h0000_1215, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send(4'd11, as[i], bs[i], exs[i]);
            wait_result(to, k, act);
            exp = sb_q.pop_front();
            n_checks++;
            if (to || k != 33) $display("FAIL mul_latency[%0d]: got k=%0d timeout=%b, expected k=33", i, k, to);
            else n_pass++;
            n_checks++;
            if (act !== exp)
                $display("FAIL mul_result[%0d]: got f=%h zf=%b cf=%b of=%b, expected f=%h zf=%b cf=%b of=%b",
                         i, act.f, act.zf, act.cf, act.of, exp.f, exp.zf, exp.cf, exp.of);
            else n_pass++;
            retire();
        end
    endtask

    task automatic test_shift_cmp();
        logic [3:0]  ops [4] = '{4'd10, 4'd7, 4'd6, 4'd13};
        logic [31:0] as  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        logic [31:0] bs  [4] = '{32'h0000_0024, 32'h0, 32'h0, 32'h1234_5678};
        res_t        exs [4];
        bit to; int k; res_t act, exp;
        exs[0] = mk(32'hF800_0000, 1'b0, 1'b0);
        exs[1] = mk(32'h1, 1'b0, 1'b0);
        exs[2] = mk(32'h0, 1'b0, 1'b0);
        exs[3] = mk(32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(ops[i], as[i], bs[i], exs[i]);
            wait_result(to, k, act);
            exp = sb_q.pop_front();
            n_checks++;
            if (to || k != 0 || act !== exp)
                $display("FAIL shift_cmp[%0d]: got k=%0d f=%h zf=%b cf=%b of=%b, expected k=0 f=%h zf=%b cf=%b of=%b",
                         i, k, act.f, act.zf, act.cf, act.of, exp.f, exp.zf, exp.cf, exp.of);
            else n_pass++;
            retire();
        end
    endtask

    task automatic test_backpressure();
        bit to; int k; res_t act, exp;
        send(4'd4, 32'h1234_0000, 32'h0000_5678, mk(32'h1234_5678, 1'b0, 1'b0));
        wait_result(to, k, act);
        exp = sb_q.pop_front();
        n_checks++;
        if (to || act !== exp)
            $display("FAIL bp_result: got f=%h timeout=%b, expected f=%h", act.f, to, exp.f);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.alu_op   = 4'd0;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.f, bus.zf, bus.cf, bus.of} !== exp)
                $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b f=%h, expected 1 0 f=%h",
                         i, bus.out_valid, bus.in_ready, bus.f, exp.f);
            else n_pass++;
        end
        retire();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: got out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit to; int k; res_t act, exp;
        send(4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, mk(32'hF00F_F00F, 1'b0, 1'b0));
        wait_result(to, k, act);
        exp = sb_q.pop_front();
        n_checks++;
        if (to || act !== exp)
            $display("FAIL b2b_first: got f=%h timeout=%b, expected f=%h", act.f, to, exp.f);
        else n_pass++;
        // New request presented on the retiring edge must not be taken there.
        bus.in_valid  = 1'b1;
        bus.alu_op    = 4'd4;
        bus.a         = 32'd10;
        bus.b         = 32'd20;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL b2b_no_accept_on_retire: got out_valid=%b in_ready=%b, expected 0 1",
                     bus.out_valid, bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.f !== 32'd30)
            $display("FAIL b2b_second: got out_valid=%b f=%h, expected 1 f=0000001e", bus.out_valid, bus.f);
        else n_pass++;
        retire();
    endtask

    task automatic test_reset_mid();
        bit to; int k; res_t act, exp;
        send(4'd11, 32'h0000_1234, 32'h0000_0100, mk(32'h0012_3400, 1'b0, 1'b0));
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.f !== 32'd0 || bus.zf !== 1'b0)
            $display("FAIL mid_reset: got out_valid=%b f=%h zf=%b, expected 0 0 0", bus.out_valid, bus.f, bus.zf);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        send(4'd4, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0));
        wait_result(to, k, act);
        exp = sb_q.pop_front();
        n_checks++;
        if (to || k != 0 || act !== exp)
            $display("FAIL post_reset_add: got k=%0d f=%h, expected k=0 f=%h", k, act.f, exp.f);
        else n_pass++;
        retire();
    endtask

    task automatic test_random();
        bit to; int k; res_t act, exp;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(15, 0));
            a  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            send(op, a, b, model(op, a, b));
            wait_result(to, k, act);
            exp = sb_q.pop_front();
            n_checks++;
            if (to || k != ((op == 4'd11) ? 33 : 0) || act !== exp)
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got k=%0d f=%h zf=%b cf=%b of=%b, expected f=%h zf=%b cf=%b of=%b",
                         i, op, a, b, k, act.f, act.zf, act.cf, act.of, exp.f, exp.zf, exp.cf, exp.of);
            else n_pass++;
            retire();
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = 4'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        test_reset();
        test_arith();
        test_mul();
        test_shift_cmp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
